// File: rtl/fdivsqrt_iter_ctrl.sv
// ---------------------------------------------------------------------------
// fdivsqrt_iter_ctrl
//
// Sequencer for an iterative radix-4 divide / square-root datapath. It
// accepts an operation request, issues a one-cycle init pulse to load the
// residual and quotient/root registers, advances the recurrence n_iter times
// (pausing while stall is high) and presents the result until the consumer
// takes it.
//
// Ports
//   clk        in   clock, rising-edge active
//   reset_n    in   asynchronous active-low reset
//   start      in   operation request, taken only while ready=1
//   sqrt_in    in   1 = square root, 0 = divide (captured on accept)
//   n_iter     in   number of radix-4 iterations (captured on accept)
//   special    in   operand needs no iteration (captured on accept)
//   stall      in   pipeline hold, freezes the iteration sequence
//   flush      in   abort current operation, back to idle next edge
//   out_ready  in   consumer accepts the result
//   ready      out  idle, able to accept start
//   init       out  one-cycle load pulse for the recurrence registers
//   iter_en    out  advance the recurrence this cycle
//   sqrt_e     out  operation type of the most recently accepted request
//   j1         out  first iteration cycle
//   jlast      out  final iteration cycle
//   out_valid  out  result available, held until out_ready
// ---------------------------------------------------------------------------
module fdivsqrt_iter_ctrl #(
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            sqrt_in,
    input  logic [CNTW-1:0] n_iter,
    input  logic            special,
    input  logic            stall,
    input  logic            flush,
    input  logic            out_ready,
    output logic            ready,
    output logic            init,
    output logic            iter_en,
    output logic            sqrt_e,
    output logic            j1,
    output logic            jlast,
    output logic            out_valid
);

    // All four encodings are live states, so no encoding is unreachable.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

    logic [1:0]      state_q,   state_d;
    logic [CNTW-1:0] cnt_q,     cnt_d;
    logic [CNTW-1:0] niter_q,   niter_d;
    logic            sqrt_q,    sqrt_d;
    logic            special_q, special_d;

    // Next-state and capture logic; flush has priority over everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        niter_d   = niter_q;
        sqrt_d    = sqrt_q;
        special_d = special_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_INIT;
                        sqrt_d    = sqrt_in;
                        niter_d   = n_iter;
                        special_d = special;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_INIT: begin
                    // Nothing to iterate: skip straight to the result.
                    if (special_q || (niter_q == CNT_ZERO)) begin
                        state_d = ST_DONE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = niter_q;
                    end
                end
                ST_BUSY: begin
                    if (!stall) begin
                        // Leave on the last iteration instead of counting to
                        // zero, so an all-ones n_iter never wraps.
                        if (cnt_q == CNT_ONE) begin
                            state_d = ST_DONE;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            state_d = ST_BUSY;
                            cnt_d   = cnt_q - CNT_ONE;
                        end
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = cnt_q;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State and operand registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            niter_q   <= CNT_ZERO;
            sqrt_q    <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            niter_q   <= niter_d;
            sqrt_q    <= sqrt_d;
            special_q <= special_d;
        end
    end

    // Output decode straight from flops, so reset reaches the outputs without
    // a clock edge; iter_en alone depends on the live stall input.
    always_comb begin
        ready     = 1'b0;
        init      = 1'b0;
        iter_en   = 1'b0;
        j1        = 1'b0;
        jlast     = 1'b0;
        out_valid = 1'b0;
        sqrt_e    = sqrt_q;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_INIT: begin
                init = 1'b1;
            end
            ST_BUSY: begin
                iter_en = ~stall;
                // cnt holds under stall, so j1/jlast hold with it.
                if (cnt_q == niter_q) begin
                    j1 = 1'b1;
                end else begin
                    j1 = 1'b0;
                end
                if (cnt_q == CNT_ONE) begin
                    jlast = 1'b1;
                end else begin
                    jlast = 1'b0;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for fdivsqrt_iter_ctrl: directed scenarios plus randomized
// traffic, every cycle compared against a transaction-level reference model
// that counts completed iterations upwards.
// ---------------------------------------------------------------------------
module tb_fdivsqrt_iter_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       sqrt_in;
    logic [5:0] n_iter;
    logic       special;
    logic       stall;
    logic       flush;
    logic       out_ready;
    logic       ready;
    logic       init;
    logic       iter_en;
    logic       sqrt_e;
    logic       j1;
    logic       jlast;
    logic       out_valid;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: 0 idle, 1 load, 2 iterating, 3 result held.
    int m_phase = 0;
    int m_done  = 0;   // iterations completed in this operation
    int m_n     = 0;
    bit m_sq    = 1'b0;
    bit m_spc   = 1'b0;

    // Outputs sampled in the most recent cycle.
    logic s_ov, s_jl, s_ie, s_j1;

    fdivsqrt_iter_ctrl #(.CNTW(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .sqrt_in   (sqrt_in),
        .n_iter    (n_iter),
        .special   (special),
        .stall     (stall),
        .flush     (flush),
        .out_ready (out_ready),
        .ready     (ready),
        .init      (init),
        .iter_en   (iter_en),
        .sqrt_e    (sqrt_e),
        .j1        (j1),
        .jlast     (jlast),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_done  = 0;
        m_sq    = 1'b0;
    endtask

    // Compare all outputs with what the model predicts for the current inputs.
    task automatic check_outputs();
        chk("ready",     int'(ready),     int'(m_phase == 0));
        chk("init",      int'(init),      int'(m_phase == 1));
        chk("iter_en",   int'(iter_en),   int'(m_phase == 2 && !stall));
        chk("j1",        int'(j1),        int'(m_phase == 2 && m_done == 0));
        chk("jlast",     int'(jlast),     int'(m_phase == 2 && m_done == m_n - 1));
        chk("out_valid", int'(out_valid), int'(m_phase == 3));
        chk("sqrt_e",    int'(sqrt_e),    int'(m_sq));
    endtask

    // Advance the model across one clock edge with the current inputs.
    task automatic model_step();
        if (flush) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                       m_phase = 1;
                       m_sq    = sqrt_in;
                       m_n     = int'(n_iter);
                       m_spc   = special;
                   end
                1: begin
                       m_done  = 0;
                       m_phase = (m_spc || m_n == 0) ? 3 : 2;
                   end
                2: if (!stall) begin
                       m_done++;
                       if (m_done == m_n) m_phase = 3;
                   end
                3: if (out_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    endtask

    // One clock cycle: drive, check mid-cycle, step model, cross the edge.
    task automatic cyc(input logic st, input logic sq, input logic [5:0] n,
                       input logic spc, input logic stl, input logic fl,
                       input logic ordy);
        start = st; sqrt_in = sq; n_iter = n; special = spc;
        stall = stl; flush = fl; out_ready = ordy;
        #2;
        s_ov = out_valid; s_jl = jlast; s_ie = iter_en; s_j1 = j1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Idle-input cycles until out_valid is seen; returns cycle index of it.
    task automatic wait_valid(input int budget, input int st_a, input int st_b,
                              input logic ordy, output int lat,
                              output int jl_at, output int ie_n, output int jl_n,
                              output int j1_at);
        lat = -1; jl_at = -1; ie_n = 0; jl_n = 0; j1_at = -1;
        for (int i = 1; i <= budget; i++) begin
            cyc(1'b0, 1'b0, 6'd0, 1'b0, (i == st_a || i == st_b), 1'b0, ordy);
            if (s_ie) ie_n++;
            if (s_jl) begin jl_n++; jl_at = i; end
            if (s_j1 && j1_at < 0) j1_at = i;
            if (s_ov) begin lat = i; break; end
        end
        if (lat < 0) chk("wait_valid_timeout", 0, 1);
    endtask

    int lat, jl_at, ie_n, jl_n, j1_at;
    int r;
    logic [5:0] rn;

    initial begin
        reset_n = 1'b0; start = 1'b0; sqrt_in = 1'b0; n_iter = 6'd0;
        special = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2;
        // Reset values present before any clock edge.
        chk("rst_ready", int'(ready), 1);
        chk("rst_ov",    int'(out_valid), 0);
        chk("rst_sqrt",  int'(sqrt_e), 0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Divide, n=4, no stall.
        cyc(1'b1, 1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(20, 0, 0, 1'b1, lat, jl_at, ie_n, jl_n, j1_at);
        chk("div4_lat", lat, 6);
        chk("div4_jlast_at", jl_at, 5);
        chk("div4_j1_at", j1_at, 2);
        chk("div4_iters", ie_n, 4);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);   // ready cycle 7 (model)

        // Sqrt, n=3, stall at cycles 3-4.
        cyc(1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(20, 3, 4, 1'b1, lat, jl_at, ie_n, jl_n, j1_at);
        chk("sqrt3_lat", lat, 7);
        chk("sqrt3_jlast_at", jl_at, 6);
        chk("sqrt3_iters", ie_n, 3);
        chk("sqrt3_sqrt_e", int'(sqrt_e), 1);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // special with n=15, then n=0 without special.
        cyc(1'b1, 1'b0, 6'd15, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_valid(20, 0, 0, 1'b1, lat, jl_at, ie_n, jl_n, j1_at);
        chk("spc_lat", lat, 2);
        chk("spc_iters", ie_n, 0);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(20, 0, 0, 1'b1, lat, jl_at, ie_n, jl_n, j1_at);
        chk("n0_lat", lat, 2);
        chk("n0_iters", ie_n, 0);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-pressure in DONE with start pulses ignored.
        cyc(1'b1, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_valid(20, 0, 0, 1'b0, lat, jl_at, ie_n, jl_n, j1_at);
        chk("bp_lat", lat, 4);
        for (int i = 0; i < 5; i++) begin
            cyc(i[0], 1'b1, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("bp_hold_ov", int'(s_ov), 1);
        end
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("bp_release_ready", int'(ready), 1);
        chk("bp_sqrt_kept", int'(sqrt_e), 0);

        // Flush at the 3rd BUSY cycle of an n=8 operation, then a fresh op.
        cyc(1'b1, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("flush_ready", int'(ready), 1);
        chk("flush_ov", int'(out_valid), 0);
        chk("flush_ie", int'(iter_en), 0);
        cyc(1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 1'b1, 1'b1);   // flush beats start
        chk("flush_start_ready", int'(ready), 1);
        cyc(1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(20, 0, 0, 1'b1, lat, jl_at, ie_n, jl_n, j1_at);
        chk("post_flush_lat", lat, 5);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-BUSY, then an all-ones iteration count.
        cyc(1'b1, 1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #2;
        chk("pre_rst_ie", int'(iter_en), 1);
        reset_n = 1'b0;
        #1;
        chk("arst_ready", int'(ready), 1);
        chk("arst_ie",    int'(iter_en), 0);
        chk("arst_j1",    int'(j1), 0);
        chk("arst_jlast", int'(jlast), 0);
        chk("arst_init",  int'(init), 0);
        chk("arst_ov",    int'(out_valid), 0);
        chk("arst_sqrt",  int'(sqrt_e), 0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        cyc(1'b1, 1'b0, 6'd63, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(100, 0, 0, 1'b1, lat, jl_at, ie_n, jl_n, j1_at);
        chk("n63_lat", lat, 65);
        chk("n63_iters", ie_n, 63);
        chk("n63_jlast_cnt", jl_n, 1);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            r = int'($urandom_range(15, 0));
            if (r == 15)      rn = 6'd63;
            else if (r > 10)  rn = 6'($urandom_range(63, 0));
            else              rn = 6'(r);
            cyc(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), rn,
                ($urandom_range(7, 0) == 0), ($urandom_range(3, 0) == 0),
                ($urandom_range(31, 0) == 0), 1'($urandom_range(1, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
